// File: rtl/uart_rx.sv
// Oversampling UART receiver: 8N1 or 8O1/8E1 frames from an asynchronous rx line,
// presented one byte at a time on a valid/ready handshake with per-byte error flags.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 1
) (
    input  logic       clk,
    input  logic       ap_rstn,
    input  logic       rx,
    output logic [7:0] data,
    output logic       ap_valid,
    input  logic       ap_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_TERM = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PARI  = 3'd3,
        ST_STOP  = 3'd4,
        ST_BRK   = 3'd5
    } state_t;

    // Value the parity bit must carry for the given data byte.
    function automatic logic expected_parity(input logic [7:0] bv);
        return (PARITY_ODD != 0) ? ~^bv : ^bv;
    endfunction

    state_t        state_q, state_d;
    logic          rx_meta_q, rx_meta_d;
    logic          rx_sync_q, rx_sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          perr_pend_q, perr_pend_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          perr_q, perr_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          rx_s;
    logic          deliver_s;
    logic          stop_low_s;

    assign rx_s = rx_sync_q;

    // Frame FSM: bit timing, sampling and byte assembly.
    always_comb begin
        rx_meta_d   = rx;
        rx_sync_d   = rx_meta_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        perr_pend_d = perr_pend_q;
        deliver_s   = 1'b0;
        stop_low_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d = CNT_ZERO;
                    if (!rx_s) begin
                        state_d     = ST_DATA;
                        idx_d       = 3'd0;
                        shift_d     = 8'h00;
                        perr_pend_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_TERM) begin
                    cnt_d          = CNT_ZERO;
                    shift_d[idx_q] = rx_s;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = (PARITY_EN != 0) ? ST_PARI : ST_STOP;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_PARI: begin
                if (cnt_q == CNT_TERM) begin
                    cnt_d       = CNT_ZERO;
                    perr_pend_d = (rx_s != expected_parity(shift_q));
                    state_d     = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_TERM) begin
                    cnt_d      = CNT_ZERO;
                    deliver_s  = 1'b1;
                    stop_low_s = !rx_s;
                    state_d    = rx_s ? ST_IDLE : ST_BRK;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_BRK: begin
                // Line held low after a bad stop: wait for idle so no repeat bytes appear.
                if (rx_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BRK;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Output holding register with valid/ready handshake and overrun detection.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        ovr_d   = 1'b0;
        if (deliver_s && (!valid_q || ap_ready)) begin
            data_d  = shift_q;
            perr_d  = perr_pend_q;
            ferr_d  = stop_low_s;
            valid_d = 1'b1;
        end else if (deliver_s) begin
            ovr_d = 1'b1;
        end else if (valid_q && ap_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State, synchroniser and output registers.
    always_ff @(posedge clk or negedge ap_rstn) begin
        if (!ap_rstn) begin
            state_q     <= ST_IDLE;
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            cnt_q       <= CNT_ZERO;
            idx_q       <= 3'd0;
            shift_q     <= 8'h00;
            perr_pend_q <= 1'b0;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= rx_meta_d;
            rx_sync_q   <= rx_sync_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            perr_pend_q <= perr_pend_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            ovr_q       <= ovr_d;
        end
    end

    assign data       = data_q;
    assign ap_valid   = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: an 8N1 instance and an 8O1 instance driven by
// bit-accurate frames, checked against a frame-level reference model.
module tb_uart_rx;

    localparam int N    = 16;
    localparam int H    = N / 2;
    localparam int LAT0 = 3 + H + 9 * N;
    localparam int LAT1 = 3 + H + 10 * N;

    typedef struct packed {
        logic [7:0]  d;
        logic        pe;
        logic        fe;
        logic [31:0] c;
    } rec_t;

    logic       clk = 1'b0;
    logic       ap_rstn;
    logic       rx0, rx1, rdy0, rdy1;
    logic [7:0] d0, d1;
    logic       v0, v1, pe0, pe1, fe0, fe1, ov0, ov1;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   vcnt0 = 0, ovr0 = 0, ovr0_cyc = 0;
    rec_t got0[$];
    rec_t got1[$];

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(N), .PARITY_EN(0), .PARITY_ODD(1)) dut0 (
        .clk(clk), .ap_rstn(ap_rstn), .rx(rx0), .data(d0), .ap_valid(v0), .ap_ready(rdy0),
        .parity_err(pe0), .frame_err(fe0), .overrun(ov0)
    );

    uart_rx #(.CLKS_PER_BIT(N), .PARITY_EN(1), .PARITY_ODD(1)) dut1 (
        .clk(clk), .ap_rstn(ap_rstn), .rx(rx1), .data(d1), .ap_valid(v1), .ap_ready(rdy1),
        .parity_err(pe1), .frame_err(fe1), .overrun(ov1)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (v0 && rdy0) got0.push_back({d0, pe0, fe0, 32'(cyc)});
        if (v1 && rdy1) got1.push_back({d1, pe1, fe1, 32'(cyc)});
        if (v0) vcnt0 <= vcnt0 + 1;
        if (ov0) begin
            ovr0     <= ovr0 + 1;
            ovr0_cyc <= cyc;
        end
    end

    // Reference: odd parity wants an odd total count of ones over data plus parity bit.
    function automatic bit model_perr(input logic [7:0] b, input bit p);
        int ones = $countones(b) + int'(p);
        return (ones % 2) == 0;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_rx(input bit which, input logic v);
        if (which) rx1 = v;
        else rx0 = v;
    endtask

    task automatic send_frame(input bit which, input logic [7:0] b, input bit pen,
                              input bit pbit, input bit stop, output int fall);
        set_rx(which, 1'b0);
        fall = cyc;
        tick(N);
        for (int i = 0; i < 8; i++) begin
            set_rx(which, b[i]);
            tick(N);
        end
        if (pen) begin
            set_rx(which, pbit);
            tick(N);
        end
        set_rx(which, stop);
        tick(N);
    endtask

    task automatic test_reset();
        ap_rstn = 1'b0;
        tick(3);
        checks++; if (d0 !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", d0); end
        checks++; if ({v0, pe0, fe0, ov0} !== 4'b0000) begin errors++; $display("FAIL reset_flags0 got=%b exp=0000", {v0, pe0, fe0, ov0}); end
        checks++; if ({d1, v1, pe1, fe1, ov1} !== 12'h000) begin errors++; $display("FAIL reset_dut1 got=%h exp=000", {d1, v1, pe1, fe1, ov1}); end
        ap_rstn = 1'b1;
        tick(4);
    endtask

    task automatic test_basic();
        int   fall, n0, vc;
        rec_t r;
        n0 = got0.size();
        vc = vcnt0;
        send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, fall);
        tick(4);
        checks++; if (got0.size() !== n0 + 1) begin errors++; $display("FAIL basic_count got=%0d exp=%0d", got0.size() - n0, 1); end
        checks++; if (vcnt0 - vc !== 1) begin errors++; $display("FAIL basic_valid_cycles got=%0d exp=1", vcnt0 - vc); end
        if (got0.size() > n0) begin
            r = got0[n0];
            checks++; if (r.d !== 8'hA5) begin errors++; $display("FAIL basic_data got=%h exp=a5", r.d); end
            checks++; if ({r.pe, r.fe} !== 2'b00) begin errors++; $display("FAIL basic_flags got=%b exp=00", {r.pe, r.fe}); end
            checks++; if (int'(r.c) - fall !== LAT0) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", int'(r.c) - fall, LAT0); end
        end
    endtask

    task automatic test_false_start();
        int n0, vc, fall;
        n0 = got0.size();
        vc = vcnt0;
        set_rx(1'b0, 1'b0);
        tick(5);
        set_rx(1'b0, 1'b1);
        tick(3 * N);
        checks++; if (vcnt0 - vc !== 0) begin errors++; $display("FAIL glitch_no_valid got=%0d exp=0", vcnt0 - vc); end
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, fall);
        tick(4);
        checks++; if (got0.size() !== n0 + 1) begin errors++; $display("FAIL glitch_count got=%0d exp=1", got0.size() - n0); end
        if (got0.size() > n0) begin
            checks++; if ({got0[n0].d, got0[n0].fe} !== {8'h3C, 1'b0}) begin errors++; $display("FAIL glitch_data got=%h/%b exp=3c/0", got0[n0].d, got0[n0].fe); end
        end
    endtask

    task automatic test_break();
        int n0, fall;
        n0 = got0.size();
        send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b0, fall);
        tick(40);
        set_rx(1'b0, 1'b1);
        tick(3 * N);
        checks++; if (got0.size() !== n0 + 1) begin errors++; $display("FAIL break_count got=%0d exp=1", got0.size() - n0); end
        if (got0.size() > n0) begin
            checks++; if ({got0[n0].d, got0[n0].pe, got0[n0].fe} !== {8'h81, 1'b0, 1'b1}) begin errors++; $display("FAIL break_byte got=%h/%b/%b exp=81/0/1", got0[n0].d, got0[n0].pe, got0[n0].fe); end
        end
        send_frame(1'b0, 8'h7E, 1'b0, 1'b0, 1'b1, fall);
        tick(4);
        checks++; if (got0.size() !== n0 + 2) begin errors++; $display("FAIL break_recover_count got=%0d exp=2", got0.size() - n0); end
        if (got0.size() > n0 + 1) begin
            checks++; if ({got0[n0+1].d, got0[n0+1].fe} !== {8'h7E, 1'b0}) begin errors++; $display("FAIL break_recover got=%h/%b exp=7e/0", got0[n0+1].d, got0[n0+1].fe); end
        end
    endtask

    task automatic test_parity();
        int n1, fall;
        n1 = got1.size();
        send_frame(1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, fall);
        tick(4);
        if (got1.size() > n1) begin
            checks++; if (int'(got1[n1].c) - fall !== LAT1) begin errors++; $display("FAIL parity_latency got=%0d exp=%0d", int'(got1[n1].c) - fall, LAT1); end
        end
        send_frame(1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, fall);
        tick(4);
        checks++; if (got1.size() !== n1 + 2) begin errors++; $display("FAIL parity_count got=%0d exp=2", got1.size() - n1); end
        if (got1.size() > n1 + 1) begin
            checks++; if ({got1[n1].d, got1[n1].pe} !== {8'hA5, 1'b0}) begin errors++; $display("FAIL parity_good got=%h/%b exp=a5/0", got1[n1].d, got1[n1].pe); end
            checks++; if ({got1[n1+1].d, got1[n1+1].pe} !== {8'hA5, 1'b1}) begin errors++; $display("FAIL parity_bad got=%h/%b exp=a5/1", got1[n1+1].d, got1[n1+1].pe); end
        end
    endtask

    task automatic test_random();
        logic [7:0] eb[10];
        bit         pb[10];
        int         n0, n1, fall;
        n0 = got0.size();
        n1 = got1.size();
        for (int i = 0; i < 10; i++) begin
            eb[i] = 8'($urandom_range(0, 255));
            send_frame(1'b0, eb[i], 1'b0, 1'b0, 1'b1, fall);
        end
        tick(4);
        checks++; if (got0.size() !== n0 + 10) begin errors++; $display("FAIL rand8n1_count got=%0d exp=10", got0.size() - n0); end
        for (int i = 0; i < 10 && n0 + i < got0.size(); i++) begin
            checks++; if ({got0[n0+i].d, got0[n0+i].pe, got0[n0+i].fe} !== {eb[i], 2'b00}) begin errors++; $display("FAIL rand8n1_byte%0d got=%h/%b/%b exp=%h/0/0", i, got0[n0+i].d, got0[n0+i].pe, got0[n0+i].fe, eb[i]); end
        end
        for (int i = 0; i < 10; i++) begin
            eb[i] = 8'($urandom_range(0, 255));
            pb[i] = 1'($urandom_range(0, 1));
            send_frame(1'b1, eb[i], 1'b1, pb[i], 1'b1, fall);
        end
        tick(4);
        checks++; if (got1.size() !== n1 + 10) begin errors++; $display("FAIL rand8o1_count got=%0d exp=10", got1.size() - n1); end
        for (int i = 0; i < 10 && n1 + i < got1.size(); i++) begin
            checks++; if ({got1[n1+i].d, got1[n1+i].pe, got1[n1+i].fe} !== {eb[i], model_perr(eb[i], pb[i]), 1'b0}) begin errors++; $display("FAIL rand8o1_byte%0d got=%h/%b exp=%h/%b", i, got1[n1+i].d, got1[n1+i].pe, eb[i], model_perr(eb[i], pb[i])); end
        end
    endtask

    task automatic test_back_to_back_overrun();
        int n0, ov, f1, f2;
        n0 = got0.size();
        ov = ovr0;
        rdy0 = 1'b0;
        send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1, f1);
        send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1, f2);
        tick(4);
        checks++; if ({v0, d0} !== {1'b1, 8'h11}) begin errors++; $display("FAIL overrun_hold got=%b/%h exp=1/11", v0, d0); end
        checks++; if (ovr0 - ov !== 1) begin errors++; $display("FAIL overrun_pulse_cycles got=%0d exp=1", ovr0 - ov); end
        checks++; if (ovr0_cyc - f2 !== LAT0) begin errors++; $display("FAIL overrun_time got=%0d exp=%0d", ovr0_cyc - f2, LAT0); end
        rdy0 = 1'b1;
        tick(3);
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL overrun_drain_valid got=%b exp=0", v0); end
        checks++; if (got0.size() !== n0 + 1) begin errors++; $display("FAIL overrun_drain_count got=%0d exp=1", got0.size() - n0); end
        if (got0.size() > n0) begin
            checks++; if (got0[n0].d !== 8'h11) begin errors++; $display("FAIL overrun_drain_data got=%h exp=11", got0[n0].d); end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] partial;
        int         n0, vc, fall;
        partial = 8'hC3;
        n0 = got0.size();
        set_rx(1'b0, 1'b0);
        tick(N);
        for (int i = 0; i < 4; i++) begin
            set_rx(1'b0, partial[i]);
            tick(N);
        end
        set_rx(1'b0, partial[4]);
        tick(H);
        ap_rstn = 1'b0;
        tick(1);
        checks++; if ({d0, v0, pe0, fe0, ov0} !== 12'h000) begin errors++; $display("FAIL midreset_outputs got=%h exp=000", {d0, v0, pe0, fe0, ov0}); end
        tick(3);
        set_rx(1'b0, 1'b1);
        ap_rstn = 1'b1;
        vc = vcnt0;
        tick(3 * N);
        checks++; if (vcnt0 - vc !== 0) begin errors++; $display("FAIL midreset_stray got=%0d exp=0", vcnt0 - vc); end
        send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, fall);
        tick(4);
        checks++; if (got0.size() !== n0 + 1) begin errors++; $display("FAIL midreset_count got=%0d exp=1", got0.size() - n0); end
        if (got0.size() > n0) begin
            checks++; if ({got0[n0].d, got0[n0].pe, got0[n0].fe} !== {8'h5A, 2'b00}) begin errors++; $display("FAIL midreset_byte got=%h exp=5a", got0[n0].d); end
        end
    endtask

    initial begin
        rx0     = 1'b1;
        rx1     = 1'b1;
        rdy0    = 1'b1;
        rdy1    = 1'b1;
        ap_rstn = 1'b0;
        test_reset();
        test_basic();
        test_false_start();
        test_break();
        test_parity();
        test_random();
        test_back_to_back_overrun();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
